pipo_rr_arbiter: RTL and testbench

Two-requester round-robin arbiter and load sequencer for the 4-bit parallel-in/parallel-out holding register in the shift-register group. It decides which requester writes the shared register, holds the captured word until the downstream consumer accepts it, and tags each word with its source. The holding register, source tag and FSM are internal. The block sits between two producers and one consumer, all valid/ready handshaked.

---
 rtl/pipo_rr_arbiter.sv | 80 ++++++++
 tb/tb_pipo_rr_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pipo_rr_arbiter.sv
// Two-requester round-robin arbiter feeding a shared WIDTH-bit holding register.
// Define PIPO_ARB_GRANT_CNT_EN to add per-requester 8-bit transfer counters.
module pipo_rr_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
`ifdef PIPO_ARB_GRANT_CNT_EN
    output logic [7:0]       gnt_cnt0,
    output logic [7:0]       gnt_cnt1,
`endif
    input  logic             out_ready
);

    localparam logic ST_EMPTY = 1'b0;
    localparam logic ST_FULL  = 1'b1;

    logic             state;
    logic             prio;
    logic             slot_open;
    logic             gnt0;
    logic             gnt1;
    logic [WIDTH-1:0] data_q;
    logic             src_q;

    // The slot is forced shut while reset is asserted so no handshake can complete.
    assign slot_open = rst_n && ((state == ST_EMPTY) || out_ready);
    assign gnt0      = slot_open && req0_valid && (!req1_valid || (prio == 1'b0));
    assign gnt1      = slot_open && req1_valid && (!req0_valid || (prio == 1'b1));

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign out_valid  = (state == ST_FULL);
    assign out_data   = data_q;
    assign out_src    = src_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_EMPTY;
            prio   <= 1'b0;
            data_q <= '0;
            src_q  <= 1'b0;
        end else if (gnt0) begin
            state  <= ST_FULL;
            prio   <= 1'b1;
            data_q <= req0_data;
            src_q  <= 1'b0;
        end else if (gnt1) begin
            state  <= ST_FULL;
            prio   <= 1'b0;
            data_q <= req1_data;
            src_q  <= 1'b1;
        end else if ((state == ST_FULL) && out_ready) begin
            // Drain without reload: word and tag stay visible but invalid.
            state  <= ST_EMPTY;
        end
    end

`ifdef PIPO_ARB_GRANT_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_cnt0 <= 8'd0;
            gnt_cnt1 <= 8'd0;
        end else begin
            if (gnt0) gnt_cnt0 <= gnt_cnt0 + 8'd1;
            if (gnt1) gnt_cnt1 <= gnt_cnt1 + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipo_rr_arbiter.sv
// Directed self-checking bench for pipo_rr_arbiter (counter checks when
// PIPO_ARB_GRANT_CNT_EN is defined).
module tb_pipo_rr_arbiter;
    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req0_valid, req1_valid;
    logic [WIDTH-1:0] req0_data, req1_data;
    logic             req0_ready, req1_ready;
    logic             out_valid, out_src, out_ready;
    logic [WIDTH-1:0] out_data;
`ifdef PIPO_ARB_GRANT_CNT_EN
    logic [7:0]       gnt_cnt0, gnt_cnt1;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    logic [3:0] exp_d [4] = '{4'h5, 4'hC, 4'h5, 4'hC};
    logic       exp_s [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    always #5 clk = ~clk;

    pipo_rr_arbiter #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_src    (out_src),
`ifdef PIPO_ARB_GRANT_CNT_EN
        .gnt_cnt0   (gnt_cnt0),
        .gnt_cnt1   (gnt_cnt1),
`endif
        .out_ready  (out_ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; out_ready = 1'b0;
        req0_valid = 1'b1; req0_data = 4'h9;
        req1_valid = 1'b0; req1_data = 4'h0;
        #12;
        check("rst_vld",  out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_src",  out_src, 0);
        check("rst_rdy0", req0_ready, 0);
        check("rst_rdy1", req1_ready, 0);
`ifdef PIPO_ARB_GRANT_CNT_EN
        check("rst_cnt0", gnt_cnt0, 0);
        check("rst_cnt1", gnt_cnt1, 0);
`endif
        step;
        rst_n = 1'b1; req0_valid = 1'b0;

        // req0 alone streams 1,2,3
        out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            req0_valid = 1'b1; req0_data = 4'(i);
            #1;
            check("single_rdy0", req0_ready, 1);
            check("single_rdy1", req1_ready, 0);
            step;
            check("single_vld",  out_valid, 1);
            check("single_data", out_data, i);
            check("single_src",  out_src, 0);
        end
        req0_valid = 1'b0;
        #1;
        check("drain1_rdy0", req0_ready, 0);
        step;
        check("drain1_vld",  out_valid, 0);
        check("drain1_data", out_data, 3);
        check("drain1_src",  out_src, 0);

        // load 7 from req0 (req1 now favoured), then hold under backpressure
        out_ready = 1'b0; req0_valid = 1'b1; req0_data = 4'h7;
        step;
        check("bp_load_vld",  out_valid, 1);
        check("bp_load_data", out_data, 4'h7);
        req0_data = 4'h5; req1_valid = 1'b1; req1_data = 4'hC;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_rdy0", req0_ready, 0);
            check("bp_rdy1", req1_ready, 0);
            step;
            check("bp_vld",  out_valid, 1);
            check("bp_data", out_data, 4'h7);
        end
        out_ready = 1'b1;
        #1;
        check("bp_rel_rdy0", req0_ready, 0);
        check("bp_rel_rdy1", req1_ready, 1);
        step;
        check("bp_rel_data", out_data, 4'hC);
        check("bp_rel_src",  out_src, 1);
        out_ready = 1'b0;
        step;

        // asynchronous reset while FULL, mid-cycle
        #3 rst_n = 1'b0;
        #1;
        check("arst_vld",  out_valid, 0);
        check("arst_data", out_data, 0);
        check("arst_src",  out_src, 0);
        check("arst_rdy0", req0_ready, 0);
        check("arst_rdy1", req1_ready, 0);
        req0_valid = 1'b0; req1_data = 4'hA;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("post_rst_rdy1", req1_ready, 1);
        check("post_rst_rdy0", req0_ready, 0);
        step;
        check("post_rst_vld",  out_valid, 1);
        check("post_rst_data", out_data, 4'hA);
        check("post_rst_src",  out_src, 1);

        // contention from reset: grants alternate req0, req1, ...
        rst_n = 1'b0; req1_valid = 1'b0;
        step;
        rst_n = 1'b1;
        req0_valid = 1'b1; req0_data = 4'h5;
        req1_valid = 1'b1; req1_data = 4'hC;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("cont_rdy0", req0_ready, !exp_s[k]);
            check("cont_rdy1", req1_ready, exp_s[k]);
            step;
            check("cont_src",  out_src, exp_s[k]);
            check("cont_data", out_data, exp_d[k]);
        end
`ifdef PIPO_ARB_GRANT_CNT_EN
        check("cont_cnt0", gnt_cnt0, 2);
        check("cont_cnt1", gnt_cnt1, 2);
`endif

        // drain to empty keeps the last word and tag
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        check("drain2_rdy0", req0_ready, 0);
        check("drain2_rdy1", req1_ready, 0);
        step;
        check("drain2_vld",  out_valid, 0);
        check("drain2_data", out_data, 4'hC);
        check("drain2_src",  out_src, 1);

`ifdef PIPO_ARB_GRANT_CNT_EN
        rst_n = 1'b0;
        step;
        rst_n = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < 257; i++) begin
            req1_data = 4'(i);
            step;
        end
        req1_valid = 1'b0;
        check("wrap_cnt1", gnt_cnt1, 1);
        check("wrap_cnt0", gnt_cnt0, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
